// File: rtl/candidate_picker.sv
// candidate_picker: latches the Similarity match-flag vector on start, scans it one
// chunk per cycle and streams the indices of set flags in ascending order over
// valid/ready. A run stops after MAX_CAND accepted indices or after the last chunk,
// then pulses finish for one cycle with the accepted count and an overflow flag.
//
// Ports:
//   i_picker_clk       clock, rising edge
//   i_picker_rst_n     asynchronous active-high reset (name kept from the codebase)
//   i_picker_start     starts a run; sampled only while idle, latches i_picker_flags
//   i_picker_flags     N_WORDS match flags, bit 0 = dictionary entry 0
//   i_picker_ready     consumer accepts o_picker_index
//   o_picker_busy      a run is in progress
//   o_picker_valid     o_picker_index holds a candidate
//   o_picker_index     dictionary index of the candidate
//   o_picker_finish    one-cycle pulse at run completion
//   o_picker_count     indices accepted this run (valid from finish until next start)
//   o_picker_overflow  set flags remained after MAX_CAND indices were accepted
module candidate_picker #(
   parameter int unsigned N_WORDS  = 500,
   parameter int unsigned CHUNK    = 20,
   parameter int unsigned MAX_CAND = 8,
   parameter int unsigned IDX_W    = $clog2(N_WORDS),
   parameter int unsigned CNT_W    = $clog2(MAX_CAND + 1)
) (
   input  logic               i_picker_clk,
   input  logic               i_picker_rst_n,
   input  logic               i_picker_start,
   input  logic [N_WORDS-1:0] i_picker_flags,
   input  logic               i_picker_ready,
   output logic               o_picker_busy,
   output logic               o_picker_valid,
   output logic [IDX_W-1:0]   o_picker_index,
   output logic               o_picker_finish,
   output logic [CNT_W-1:0]   o_picker_count,
   output logic               o_picker_overflow
);

   localparam int unsigned NUM_CHUNKS = (N_WORDS + CHUNK - 1) / CHUNK;
   localparam int unsigned PAD_W      = NUM_CHUNKS * CHUNK;
   localparam int unsigned PTR_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam int unsigned OFF_W      = (CHUNK > 1) ? $clog2(CHUNK) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_EMIT,
      S_DONE
   } state_t;

   state_t             r_state;
   logic [N_WORDS-1:0] r_mask;
   logic [PTR_W-1:0]   r_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               r_busy;
   logic               r_valid;
   logic [IDX_W-1:0]   r_index;
   logic               r_finish;
   logic               r_overflow;

   logic [PAD_W-1:0]   w_mask_pad;
   logic [IDX_W-1:0]   w_base;
   logic [CHUNK-1:0]   w_chunk;
   logic [OFF_W-1:0]   w_off;
   logic [IDX_W-1:0]   w_idx;
   logic               w_hit;
   logic               w_last;

   // Zero-extend the mask so the final chunk reads absent entries as 0.
   always_comb begin
      w_mask_pad                = '0;
      w_mask_pad[N_WORDS-1:0]   = r_mask;
   end

   assign w_base  = IDX_W'(r_ptr) * IDX_W'(CHUNK);
   assign w_chunk = w_mask_pad[w_base +: CHUNK];
   assign w_hit   = |w_chunk;
   assign w_last  = (r_ptr == PTR_W'(NUM_CHUNKS - 1));

   // Priority encoder: lowest set bit in the current chunk (descending loop, last write wins).
   always_comb begin
      w_off = '0;
      for (int i = CHUNK - 1; i >= 0; i--) begin
         if (w_chunk[i]) begin
            w_off = OFF_W'(i);
         end
      end
   end

   assign w_idx = w_base + IDX_W'(w_off);

   // Control FSM with registered outputs.
   always_ff @(posedge i_picker_clk or posedge i_picker_rst_n) begin
      if (i_picker_rst_n) begin
         r_state    <= S_IDLE;
         r_mask     <= '0;
         r_ptr      <= '0;
         r_count    <= '0;
         r_busy     <= 1'b0;
         r_valid    <= 1'b0;
         r_index    <= '0;
         r_finish   <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_finish <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_picker_start) begin
                  r_mask     <= i_picker_flags;
                  r_ptr      <= '0;
                  r_count    <= '0;
                  r_overflow <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (w_hit) begin
                  // Clearing the emitted bit lets the same chunk be rescanned after the handshake.
                  r_index       <= w_idx;
                  r_valid       <= 1'b1;
                  r_mask[w_idx] <= 1'b0;
                  r_state       <= S_EMIT;
               end else if (w_last) begin
                  r_finish <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  r_ptr <= r_ptr + PTR_W'(1);
               end
            end
            S_EMIT: begin
               if (i_picker_ready) begin
                  r_valid <= 1'b0;
                  r_count <= r_count + CNT_W'(1);
                  if (r_count == CNT_W'(MAX_CAND - 1)) begin
                     r_overflow <= |r_mask;
                     r_finish   <= 1'b1;
                     r_state    <= S_DONE;
                  end else begin
                     r_state <= S_SCAN;
                  end
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_picker_busy     = r_busy;
   assign o_picker_valid    = r_valid;
   assign o_picker_index    = r_index;
   assign o_picker_finish   = r_finish;
   assign o_picker_count    = r_count;
   assign o_picker_overflow = r_overflow;

endmodule

// File: tb/tb_candidate_picker.sv
// Testbench for candidate_picker: table of directed runs, a reset-abort sequence and
// randomized runs, all checked against a list-based reference model.
module tb_candidate_picker;

   localparam int unsigned N     = 500;
   localparam int unsigned CH    = 20;
   localparam int unsigned NCH   = 25;
   localparam int unsigned MAXC  = 8;
   localparam int          BUDGET = 400;

   logic           clk;
   logic           rst;
   logic           start;
   logic [N-1:0]   flags;
   logic           ready;
   logic           busy;
   logic           valid;
   logic [8:0]     index;
   logic           finish;
   logic [3:0]     count;
   logic           overflow;

   candidate_picker dut (
      .i_picker_clk      (clk),
      .i_picker_rst_n    (rst),
      .i_picker_start    (start),
      .i_picker_flags    (flags),
      .i_picker_ready    (ready),
      .o_picker_busy     (busy),
      .o_picker_valid    (valid),
      .o_picker_index    (index),
      .o_picker_finish   (finish),
      .o_picker_count    (count),
      .o_picker_overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Results of the last run and expectations from the model.
   int got_idx[$];
   int got_cyc[$];
   int exp_idx[$];
   bit exp_ovf;
   int fin_cyc;
   int fin_count;
   int fin_ovf;
   int stable_err;
   int stall_cnt;

   typedef struct {
      string        name;
      logic [N-1:0] flags;
      int           mode;       // 0 ready high, 1 random ready, 2 ten-cycle stall on first valid
      bit           restart;
      logic [N-1:0] rflags;
      int           exp_count;
      bit           exp_ovf;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: ascending list of set flags, truncated to MAXC; overflow if any were cut.
   task automatic model(input logic [N-1:0] f);
      exp_idx.delete();
      exp_ovf = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if (f[i]) begin
            if (exp_idx.size() < int'(MAXC)) exp_idx.push_back(i);
            else exp_ovf = 1'b1;
         end
      end
   endtask

   task automatic run_case(input string name, input logic [N-1:0] f, input int mode,
                           input bit restart, input logic [N-1:0] rf);
      bit   prev_v;
      bit   prev_r;
      int   prev_i;
      int   vstart;
      int   stall_left;
      bit   stalled;
      got_idx.delete();
      got_cyc.delete();
      fin_cyc = -1; fin_count = -1; fin_ovf = -1;
      stable_err = 0; stall_cnt = 0;
      prev_v = 0; prev_r = 1; prev_i = 0; vstart = 0; stall_left = 0; stalled = 0;
      @(negedge clk);
      flags = f; start = 1'b1; ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 1; cyc <= BUDGET; cyc++) begin
         if (restart && cyc == 3) begin
            flags = rf; start = 1'b1;
         end else begin
            flags = f; start = 1'b0;
         end
         case (mode)
            0: ready = 1'b1;
            1: ready = ($urandom_range(0, 3) != 0);
            default: begin
               if (valid && !stalled) begin
                  stalled = 1; stall_left = 10;
               end
               ready = (stall_left == 0);
               if (stall_left > 0) stall_left--;
            end
         endcase
         if (cyc == 1) chk({name, "/busy_at_start"}, int'(busy), 1);
         if (prev_v && !prev_r) begin
            if (!valid || int'(index) != prev_i) stable_err++;
         end
         if (valid && !prev_v) vstart = cyc;
         if (valid && !ready) stall_cnt++;
         if (valid && ready) begin
            got_idx.push_back(int'(index));
            got_cyc.push_back(vstart);
         end
         if (finish) begin
            fin_cyc = cyc; fin_count = int'(count); fin_ovf = int'(overflow);
            start = 1'b0;
            @(negedge clk);
            chk({name, "/finish_one_cycle"}, int'(finish), 0);
            chk({name, "/idle_after"}, int'(busy), 0);
            chk({name, "/count_held"}, int'(count), fin_count);
            break;
         end
         prev_v = valid; prev_r = ready; prev_i = int'(index);
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic compare(input string name, input int mode, input int ec, input bit eo);
      int n;
      chk({name, "/finish_seen"}, int'(fin_cyc >= 0), 1);
      chk({name, "/count"}, fin_count, ec);
      chk({name, "/overflow"}, fin_ovf, int'(eo));
      chk({name, "/num_indices"}, got_idx.size(), exp_idx.size());
      chk({name, "/stable_while_stalled"}, stable_err, 0);
      n = (got_idx.size() < exp_idx.size()) ? got_idx.size() : exp_idx.size();
      for (int j = 0; j < n; j++) begin
         chk($sformatf("%s/index%0d", name, j), got_idx[j], exp_idx[j]);
         // With ready held high each candidate costs exactly two extra cycles.
         if (mode == 0)
            chk($sformatf("%s/valid_cycle%0d", name, j), got_cyc[j],
                exp_idx[j] / int'(CH) + 2 + 2 * j);
      end
      if (mode == 0 && fin_cyc >= 0) begin
         if (exp_idx.size() == int'(MAXC))
            chk({name, "/finish_cycle"}, fin_cyc,
                exp_idx[MAXC-1] / int'(CH) + 2 + 2 * (int'(MAXC) - 1) + 1);
         else
            chk({name, "/finish_cycle"}, fin_cyc, int'(NCH) + 1 + 2 * exp_idx.size());
      end
   endtask

   initial begin
      logic [N-1:0] f;
      int           thr;
      int           mode;
      bit           seen;

      rst = 1'b0; start = 1'b0; flags = '0; ready = 1'b0;

      // Reset state.
      #2 rst = 1'b1;
      #1;
      chk("reset/busy", int'(busy), 0);
      chk("reset/valid", int'(valid), 0);
      chk("reset/index", int'(index), 0);
      chk("reset/finish", int'(finish), 0);
      chk("reset/count", int'(count), 0);
      chk("reset/overflow", int'(overflow), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Directed table.
      tbl[0] = '{name:"zero", flags:'0, mode:0, restart:0, rflags:'0, exp_count:0, exp_ovf:0};
      f = '0; f[3] = 1; f[18] = 1; f[120] = 1; f[499] = 1;
      tbl[1] = '{name:"sparse4", flags:f, mode:0, restart:0, rflags:'0, exp_count:4, exp_ovf:0};
      f = '0; f[5] = 1; f[6] = 1;
      tbl[2] = '{name:"stall56", flags:f, mode:2, restart:0, rflags:'0, exp_count:2, exp_ovf:0};
      f = '0; for (int i = 0; i < 10; i++) f[i] = 1;
      tbl[3] = '{name:"ovf10", flags:f, mode:0, restart:0, rflags:'0, exp_count:8, exp_ovf:1};
      f = '0; for (int i = 0; i < 8; i++) f[i] = 1;
      tbl[4] = '{name:"full8", flags:f, mode:0, restart:0, rflags:'0, exp_count:8, exp_ovf:0};
      f = '0; f[40] = 1; f[41] = 1; f[300] = 1;
      tbl[5] = '{name:"restart", flags:f, mode:0, restart:1, rflags:'0, exp_count:3, exp_ovf:0};
      tbl[5].rflags[1] = 1; tbl[5].rflags[2] = 1; tbl[5].rflags[3] = 1;

      for (int t = 0; t < 6; t++) begin
         model(tbl[t].flags);
         run_case(tbl[t].name, tbl[t].flags, tbl[t].mode, tbl[t].restart, tbl[t].rflags);
         compare(tbl[t].name, tbl[t].mode, tbl[t].exp_count, tbl[t].exp_ovf);
         if (t == 2) chk("stall56/stall_cycles", stall_cnt, 10);
      end

      // Reset asserted while a candidate is pending.
      @(negedge clk);
      f = '0; f[5] = 1;
      flags = f; start = 1'b1; ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         if (valid) seen = 1;
         else @(negedge clk);
      end
      chk("abort/valid_before_reset", int'(seen), 1);
      chk("abort/index_before_reset", int'(index), 5);
      #2 rst = 1'b1;
      #1;
      chk("abort/busy", int'(busy), 0);
      chk("abort/valid", int'(valid), 0);
      chk("abort/index", int'(index), 0);
      chk("abort/finish", int'(finish), 0);
      chk("abort/count", int'(count), 0);
      chk("abort/overflow", int'(overflow), 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("abort/no_finish%0d", c), int'(finish), 0);
      end
      rst = 1'b0;
      ready = 1'b1;
      f = '0; f[2] = 1; f[40] = 1;
      model(f);
      run_case("after_abort", f, 0, 0, '0);
      compare("after_abort", 0, exp_idx.size(), exp_ovf);

      // Randomized runs against the model.
      for (int r = 0; r < 20; r++) begin
         case ($urandom_range(0, 2))
            0: thr = 2;
            1: thr = 10;
            default: thr = 30;
         endcase
         f = '0;
         for (int i = 0; i < int'(N); i++) f[i] = ($urandom_range(0, 999) < thr);
         mode = int'($urandom_range(0, 1));
         model(f);
         run_case($sformatf("rand%0d", r), f, mode, 0, '0);
         compare($sformatf("rand%0d", r), mode, exp_idx.size(), exp_ovf);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
